lstm_act_scheduler: RTL and testbench
=====================================

# lstm_act_scheduler

Time-shares a single LSTM activation unit (sigmoid/tanh LUT-plus-interpolator, 8-bit signed in/out) among N gate requesters: input, forget, output and candidate gates. It arbitrates round-robin, drives the shared unit's operand and function select from a pipeline register, and captures the result. Each result is returned with its requester ID on a valid/ready response port. It sits between the gate pre-activation adders and the cell-state update logic of one LSTM layer.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width; must satisfy 2^ID_W >= N_REQ
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_z  in  8*N_REQ  signed pre-activation per requester; requester i uses bits [8i+7:8i]
- req_func  in  N_REQ  per-requester function: 0 = sigmoid, 1 = tanh
- req_ready  out  N_REQ  one-hot grant/accept; reset 0
- act_z  out  8  operand to shared activation unit; reset 0
- act_func  out  1  function select to shared unit; reset 0
- act_a  in  8  combinational result from shared unit for current act_z/act_func
- rsp_valid  out  1  result valid; reset 0
- rsp_a  out  8  signed activation result; reset 0
- rsp_id  out  ID_W  requester index of result; reset 0
- rsp_ready  in  1  downstream accepts result

## Operation
- Two pipeline stages:
  - S1 (issue): valid bit plus act_z, act_func and ID.
  - S2 (result): rsp_valid, rsp_a and rsp_id.
- adv2 = !rsp_valid | rsp_ready. When adv2: S2 <= S1 (rsp_a <= act_a, rsp_id <= S1 ID, rsp_valid <= S1 valid).
- adv1 = !S1_valid | adv2. When adv1, S1 loads the granted request if any; otherwise S1_valid <= 0.
- Arbitration, combinational:
  - Search req_valid from pointer ptr upward, modulo N_REQ; first set bit wins.
  - req_ready[i] = adv1 & grant[i]. At most one bit is set.
  - A transfer occurs when req_valid[i] & req_ready[i].
- Pointer:
  - ptr resets to 0.
  - On a transfer from requester i, ptr <= (i+1) mod N_REQ.
  - With no transfer, ptr holds.
- act_z and act_func hold their last value while S1 is empty. No X propagation into the shared unit.
- Requester data is sampled only on a transfer. A requester may drop req_valid before it is granted.
- Ordering: results leave in grant order. No reordering, no drops.
- Reset mid-operation: S1 and S2 are cleared immediately and asynchronously and ptr is set to 0. In-flight results are lost, and requesters must reissue.

## Timing
- Latency: a transfer at edge k gives rsp_valid = 1 after edge k+1, provided S2 is free. act_a is captured at edge k+1.
- Throughput: one result per cycle while rsp_ready = 1.
- Backpressure: rsp_valid & !rsp_ready holds S2 stable.
  - S1 holds if it is occupied.
  - req_ready is all zero while both stages are full.
- Simultaneous drain and fill: when S2 drains on the same edge that S1 moves into S2, S1 accepts a new request on that edge. There are no bubbles.
- The shared unit is purely combinational from act_z/act_func to act_a within one cycle.

## Configuration
- LSTM_ACT_SCHED_STATS_EN defined:
  - Adds output stall_cnt [15:0], reset 0.
  - Increments on each cycle with rsp_valid & !rsp_ready, saturating at 16'hFFFF.
  - Adds input stall_clr [1], which zeroes the counter synchronously. stall_clr has priority over increment.
- Macro undefined: stall_cnt and stall_clr ports are absent and there is no counter logic.

## Test plan
Bench model of the shared unit: act_a = act_func ? ~act_z : act_z + 1.
- Reset, then req_valid[2]=1, req_z=8'h10, func=0, rsp_ready=1 -> req_ready=4'b0100 for one cycle. One cycle later rsp_valid=1, rsp_a=8'h11, rsp_id=2.
- All four requesters valid continuously, rsp_ready=1 -> grants cycle 0,1,2,3,0 on consecutive cycles. rsp_id follows the same sequence, one result per cycle.
- rsp_ready=0 with requesters 0 and 1 valid -> two transfers, then req_ready=0. rsp_a/rsp_id stay stable. After rsp_ready=1, results arrive in grant order 0,1 with no loss.
- Requester 3 with func=1, z=8'h80 -> rsp_a=8'h7F and rsp_id=3. act_func=1 while in S1.
- Assert rst low while S1 and S2 are full -> rsp_valid, req_ready, act_z and rsp_a are 0 immediately. After release, the first grant goes to requester 0 when all are valid.
- With LSTM_ACT_SCHED_STATS_EN: hold rsp_ready=0 for 5 cycles with rsp_valid=1 -> stall_cnt=5. Pulse stall_clr -> 0.

Source files
------------

// File: rtl/lstm_act_scheduler.sv
// Round-robin scheduler sharing one 8-bit LSTM activation unit among N_REQ gate requesters.
// Optional stall counter enabled by defining LSTM_ACT_SCHED_STATS_EN.
module lstm_act_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [8*N_REQ-1:0]   i_req_z,
    input  logic [N_REQ-1:0]     i_req_func,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [7:0]           o_act_z,
    output logic                 o_act_func,
    input  logic [7:0]           i_act_a,
    output logic                 o_rsp_valid,
    output logic [7:0]           o_rsp_a,
    output logic [ID_W-1:0]      o_rsp_id,
`ifdef LSTM_ACT_SCHED_STATS_EN
    output logic [15:0]          o_stall_cnt,
    input  logic                 i_stall_clr,
`endif
    input  logic                 i_rsp_ready
);

    logic              r_s1_valid;
    logic [ID_W-1:0]   r_s1_id;
    logic [ID_W-1:0]   r_ptr;

    logic              w_adv1;
    logic              w_adv2;
    logic              w_found;
    logic              w_xfer;
    logic [ID_W-1:0]   w_gnt_id;
    logic [N_REQ-1:0]  w_grant;
    logic [7:0]        w_sel_z;
    logic              w_sel_func;

    assign w_adv2 = !o_rsp_valid || i_rsp_ready;
    assign w_adv1 = !r_s1_valid || w_adv2;

    // Rotating priority search starting at r_ptr
    always_comb begin
        int unsigned idx;
        idx        = 0;
        w_found    = 1'b0;
        w_gnt_id   = '0;
        w_sel_z    = '0;
        w_sel_func = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(r_ptr) + k) % N_REQ;
            if (!w_found && i_req_valid[idx]) begin
                w_found    = 1'b1;
                w_gnt_id   = ID_W'(idx);
                w_sel_z    = i_req_z[8*idx +: 8];
                w_sel_func = i_req_func[idx];
            end
        end
    end

    assign w_grant     = w_found ? (N_REQ'(1) << w_gnt_id) : '0;
    assign o_req_ready = (w_adv1 && i_rst_n) ? w_grant : '0;
    assign w_xfer      = w_found && w_adv1;

    // S1: issue stage; operand and function hold while empty
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            o_act_z    <= '0;
            o_act_func <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_id    <= w_gnt_id;
                o_act_z    <= w_sel_z;
                o_act_func <= w_sel_func;
            end
        end
    end

    // S2: result stage captures the shared unit output
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid <= 1'b0;
            o_rsp_a     <= '0;
            o_rsp_id    <= '0;
        end else if (w_adv2) begin
            o_rsp_valid <= r_s1_valid;
            o_rsp_a     <= i_act_a;
            o_rsp_id    <= r_s1_id;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
        end
    end

`ifdef LSTM_ACT_SCHED_STATS_EN
    // Saturating count of backpressured result cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (i_stall_clr) begin
            o_stall_cnt <= '0;
        end else if (o_rsp_valid && !i_rsp_ready && (o_stall_cnt != 16'hFFFF)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lstm_act_scheduler.sv
// Scoreboard bench for lstm_act_scheduler: directed stimulus pushes expected {id, a}; a monitor pops on each response handshake.
module tb_lstm_act_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_z;
    logic [3:0]  req_func;
    logic [3:0]  req_ready;
    logic [7:0]  act_z;
    logic        act_func;
    logic [7:0]  act_a;
    logic        rsp_valid;
    logic [7:0]  rsp_a;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
`ifdef LSTM_ACT_SCHED_STATS_EN
    logic [15:0] stall_cnt;
    logic        stall_clr;
`endif

    int n_tests;
    int n_fail;
    logic [9:0] exp_q[$];

    lstm_act_scheduler #(.N_REQ(4), .ID_W(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_z     (req_z),
        .i_req_func  (req_func),
        .o_req_ready (req_ready),
        .o_act_z     (act_z),
        .o_act_func  (act_func),
        .i_act_a     (act_a),
        .o_rsp_valid (rsp_valid),
        .o_rsp_a     (rsp_a),
        .o_rsp_id    (rsp_id),
`ifdef LSTM_ACT_SCHED_STATS_EN
        .o_stall_cnt (stall_cnt),
        .i_stall_clr (stall_clr),
`endif
        .i_rsp_ready (rsp_ready)
    );

    // Shared activation unit stand-in
    always_comb act_a = act_func ? ~act_z : act_z + 8'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic push(input int id, input logic [7:0] a);
        exp_q.push_back({2'(id), a});
    endtask

    // Response monitor: a handshake seen at negedge completes on the next posedge
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {22'd0, rsp_id, rsp_a}, 32'h3FF);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e[9:8]));
                chk("rsp_a", 32'(rsp_a), 32'(e[7:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_z     = '0;
        req_func  = '0;
        rsp_ready = 1'b0;
`ifdef LSTM_ACT_SCHED_STATS_EN
        stall_clr = 1'b0;
`endif
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_act_z", 32'(act_z), 32'h0);
        chk("rst_act_func", 32'(act_func), 32'h0);
        chk("rst_rsp_a", 32'(rsp_a), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        step();
        rst_n = 1'b1;

        // Single request from requester 2, sigmoid
        req_valid     = 4'b0100;
        req_z[23:16]  = 8'h10;
        rsp_ready     = 1'b1;
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'h4);
        push(2, 8'h11);
        step();
        req_valid = '0;
        chk("t1_act_z", 32'(act_z), 32'h10);
        chk("t1_rsp_valid_early", 32'(rsp_valid), 32'h0);
        step();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_a", 32'(rsp_a), 32'h11);
        chk("t1_rsp_id", 32'(rsp_id), 32'h2);
        step();

        // All requesters valid: grants rotate 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) req_z[8*i +: 8] = 8'(8'h20 + i);
        req_func  = '0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            #1;
            chk("t2_grant", 32'(req_ready), 32'(4'b0001 << g));
            push(g, 8'(8'h21 + g));
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Backpressure: two transfers then stall
        do_reset();
        req_z[7:0]  = 8'h05;
        req_z[15:8] = 8'h06;
        rsp_ready   = 1'b0;
        req_valid   = 4'b0011;
        #1;
        chk("t3_grant0", 32'(req_ready), 32'h1);
        push(0, 8'h06);
        step();
        chk("t3_grant1", 32'(req_ready), 32'h2);
        push(1, 8'h07);
        step();
        chk("t3_full_ready", 32'(req_ready), 32'h0);
        chk("t3_hold_id", 32'(rsp_id), 32'h0);
        chk("t3_hold_a", 32'(rsp_a), 32'h06);
        step();
        step();
        chk("t3_hold_id2", 32'(rsp_id), 32'h0);
        chk("t3_hold_a2", 32'(rsp_a), 32'h06);
        chk("t3_full_ready2", 32'(req_ready), 32'h0);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) step();

        // Requester 3, tanh of 0x80
        req_z[31:24] = 8'h80;
        req_func     = 4'b1000;
        req_valid    = 4'b1000;
        #1;
        chk("t4_grant", 32'(req_ready), 32'h8);
        push(3, 8'h7F);
        step();
        req_valid = '0;
        chk("t4_act_func", 32'(act_func), 32'h1);
        chk("t4_act_z", 32'(act_z), 32'h80);
        step();
        chk("t4_rsp_a", 32'(rsp_a), 32'h7F);
        chk("t4_rsp_id", 32'(rsp_id), 32'h3);
        step();
        req_func = '0;

        // Asynchronous reset with both stages full
        for (int i = 0; i < 4; i++) req_z[8*i +: 8] = 8'(8'h40 + i);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        step();
        step();
        chk("t5_full_ready", 32'(req_ready), 32'h0);
        chk("t5_full_valid", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t5_rst_req_ready", 32'(req_ready), 32'h0);
        chk("t5_rst_act_z", 32'(act_z), 32'h0);
        chk("t5_rst_rsp_a", 32'(rsp_a), 32'h0);
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("t5_first_grant", 32'(req_ready), 32'h1);
        push(0, 8'h41);
        step();
        req_valid = '0;
        repeat (3) step();

`ifdef LSTM_ACT_SCHED_STATS_EN
        // Stall counter: five stalled cycles, then clear
        do_reset();
        req_z[7:0] = 8'h55;
        rsp_ready  = 1'b0;
        req_valid  = 4'b0001;
        push(0, 8'h56);
        step();
        req_valid = '0;
        step();
        chk("stats_zero", 32'(stall_cnt), 32'h0);
        repeat (5) step();
        chk("stats_five", 32'(stall_cnt), 32'd5);
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        chk("stats_clr", 32'(stall_cnt), 32'h0);
        rsp_ready = 1'b1;
        repeat (3) step();
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
